mmio_fabric: RTL and testbench

//  Parametrised memory-mapped interconnect between the MIPS data port and N slave peripherals (dmem, factorial, GPIO, ...).

---
 rtl/mmio_fabric.sv | 136 +++++++++++++
 tb/tb_mmio_fabric.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_fabric.sv
// Memory-mapped interconnect from the CPU data port to NUM_SLAVES peripherals.
// Region-decoded, ready-handshaked accesses with timeout, registered response and error log.
module mmio_fabric #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REGION_LSB = 8,
  parameter int unsigned REGION_W   = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [31:0]                  cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wd,
  output logic [DATA_W-1:0]            cpu_rd,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [NUM_SLAVES-1:0]        s_we,
  output logic [31:0]                  s_addr,
  output logic [DATA_W-1:0]            s_wd,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rd,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  output logic [7:0]                   err_count,
  output logic [31:0]                  err_addr
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                  state_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic                    we_q;
  logic [31:0]             addr_q;
  logic [DATA_W-1:0]       wd_q;
  logic [7:0]              cnt_q;
  logic [DATA_W-1:0]       rd_q;
  logic                    err_q;
  logic                    ready_q;
  logic [7:0]              err_count_q;
  logic [31:0]             err_addr_q;

  logic [REGION_W-1:0]     region;
  logic [NUM_SLAVES-1:0]   dec;
  logic [DATA_W-1:0]       slave_rd;
  logic                    hit;

  // Region values >= NUM_SLAVES match no decode bit, so dec == 0 means unmapped.
  always_comb begin
    region = cpu_addr[REGION_LSB +: REGION_W];
    dec    = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      dec[i] = (region == REGION_W'(i));
    end
  end

  always_comb begin
    slave_rd = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) slave_rd = slave_rd | s_rd[i*DATA_W +: DATA_W];
    end
    hit = |(sel_q & s_ready);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req) begin
            addr_q <= cpu_addr;
            we_q   <= cpu_we;
            wd_q   <= cpu_wd;
            cnt_q  <= '0;
            if (|dec) begin
              sel_q   <= dec;
              state_q <= StAccess;
            end else begin
              sel_q       <= '0;
              ready_q     <= 1'b1;
              err_q       <= 1'b1;
              err_addr_q  <= cpu_addr;
              err_count_q <= (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
              state_q     <= StResp;
            end
          end
        end
        StAccess: begin
          // A ready in the final permitted cycle wins over the timeout.
          if (hit) begin
            ready_q <= 1'b1;
            rd_q    <= we_q ? '0 : slave_rd;
            sel_q   <= '0;
            state_q <= StResp;
          end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            ready_q     <= 1'b1;
            err_q       <= 1'b1;
            sel_q       <= '0;
            err_addr_q  <= addr_q;
            err_count_q <= (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_rd    = rd_q;
  assign cpu_ready = ready_q;
  assign cpu_err   = err_q;
  assign s_sel     = sel_q;
  assign s_we      = sel_q & {NUM_SLAVES{we_q}};
  assign s_addr    = addr_q;
  assign s_wd      = wd_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed self-checking bench for mmio_fabric: decode, wait states, timeout, reset abort,
// error statistics and back-to-back requests.
module tb_mmio_fabric;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wd = '0;
  logic [31:0]  cpu_rd;
  logic         cpu_ready;
  logic         cpu_err;
  logic [3:0]   s_sel;
  logic [3:0]   s_we;
  logic [31:0]  s_addr;
  logic [31:0]  s_wd;
  logic [127:0] s_rd = {32'h33334444, 32'hCAFE0001, 32'h11112222, 32'hA5A50000};
  logic [3:0]   s_ready = '0;
  logic [7:0]   err_count;
  logic [31:0]  err_addr;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_fabric dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wd    (cpu_wd),
    .cpu_rd    (cpu_rd),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wd      (s_wd),
    .s_rd      (s_rd),
    .s_ready   (s_ready),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge; the edge that samples it is the accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_wd   = wd;
    tick();
    cpu_req  = 1'b0;
  endtask

  // Latency counts the edge at which cpu_ready is sampled, relative to the accept edge.
  task automatic wait_ready(output int lat);
    lat = 1;
    while (!cpu_ready && lat < 40) begin
      tick();
      lat++;
    end
    if (!cpu_ready) lat = 99;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cpu_rd, cpu_ready, cpu_err, s_sel, s_we, s_addr, s_wd, err_count, err_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%h rdy=%b err=%b sel=%b we=%b cnt=%0d, want all zero",
               cpu_rd, cpu_ready, cpu_err, s_sel, s_we, err_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int lat;
    s_ready = 4'b0100;
    issue(1'b0, 32'h0000_0204, 32'h0);
    n_checks++;
    if (s_sel !== 4'b0100 || s_we !== 4'b0000) begin
      n_fail++;
      $display("FAIL read_sel: got sel=%b we=%b want sel=0100 we=0000", s_sel, s_we);
    end
    wait_ready(lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL read_latency: got %0d want 2", lat);
    end
    n_checks++;
    if (cpu_rd !== 32'hCAFE0001 || cpu_err !== 1'b0) begin
      n_fail++;
      $display("FAIL read_data: got rd=%h err=%b want rd=cafe0001 err=0", cpu_rd, cpu_err);
    end
    tick();
    n_checks++;
    if (cpu_ready !== 1'b0 || cpu_rd !== 32'h0 || s_sel !== 4'b0) begin
      n_fail++;
      $display("FAIL read_after: got rdy=%b rd=%h sel=%b want 0 0 0", cpu_ready, cpu_rd, s_sel);
    end
    s_ready = 4'b0000;
  endtask

  task automatic test_write_wait();
    int lat = 1;
    int sel_cnt = 0;
    s_ready = 4'b0000;
    issue(1'b1, 32'h0000_0104, 32'h5);
    for (int i = 0; i < 3; i++) begin
      if (s_sel === 4'b0010 && s_we === 4'b0010 && s_addr === 32'h104 && s_wd === 32'h5)
        sel_cnt++;
      tick();
      lat++;
    end
    s_ready = 4'b0010;
    if (s_sel === 4'b0010 && s_we === 4'b0010) sel_cnt++;
    tick();
    lat++;
    s_ready = 4'b0000;
    n_checks++;
    if (sel_cnt !== 4) begin
      n_fail++;
      $display("FAIL write_sel_cycles: got %0d want 4", sel_cnt);
    end
    n_checks++;
    if (cpu_ready !== 1'b1 || lat !== 5) begin
      n_fail++;
      $display("FAIL write_latency: got rdy=%b at %0d want rdy=1 at 5", cpu_ready, lat);
    end
    n_checks++;
    if (cpu_err !== 1'b0 || cpu_rd !== 32'h0 || s_sel !== 4'b0 || s_we !== 4'b0) begin
      n_fail++;
      $display("FAIL write_resp: got err=%b rd=%h sel=%b we=%b want 0 0 0 0",
               cpu_err, cpu_rd, s_sel, s_we);
    end
    tick();
  endtask

  task automatic test_unmapped();
    int lat;
    s_ready = 4'b1111;
    issue(1'b0, 32'h0000_0F00, 32'h0);
    n_checks++;
    if (s_sel !== 4'b0) begin
      n_fail++;
      $display("FAIL unmapped_sel: got %b want 0000", s_sel);
    end
    wait_ready(lat);
    n_checks++;
    if (lat !== 1 || cpu_err !== 1'b1 || cpu_rd !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_resp: got lat=%0d err=%b rd=%h want 1 1 0", lat, cpu_err, cpu_rd);
    end
    n_checks++;
    if (err_count !== 8'd1 || err_addr !== 32'h0F00) begin
      n_fail++;
      $display("FAIL unmapped_log: got cnt=%0d addr=%h want 1 00000f00", err_count, err_addr);
    end
    tick();
    s_ready = 4'b0000;
  endtask

  // late=1: slave 3 answers in the 15th (last permitted) ACCESS cycle.
  task automatic test_timeout(input logic late);
    int lat = 1;
    int sel_cnt = 0;
    s_ready = 4'b0111;
    issue(1'b0, 32'h0000_0300, 32'h0);
    while (!cpu_ready && lat < 40) begin
      if (s_sel === 4'b1000) sel_cnt++;
      if (late && sel_cnt == 15) s_ready = 4'b1111;
      tick();
      lat++;
    end
    s_ready = 4'b0000;
    n_checks++;
    if (sel_cnt !== 15 || lat !== 16) begin
      n_fail++;
      $display("FAIL timeout_cycles(late=%0b): got sel=%0d lat=%0d want 15 16", late, sel_cnt, lat);
    end
    n_checks++;
    if (cpu_err !== !late || cpu_rd !== (late ? 32'h33334444 : 32'h0)) begin
      n_fail++;
      $display("FAIL timeout_resp(late=%0b): got err=%b rd=%h", late, cpu_err, cpu_rd);
    end
    n_checks++;
    if (err_count !== 8'd2 || err_addr !== 32'h0300) begin
      n_fail++;
      $display("FAIL timeout_log(late=%0b): got cnt=%0d addr=%h want 2 00000300",
               late, err_count, err_addr);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen = 1'b0;
    s_ready = 4'b0000;
    issue(1'b1, 32'h0000_0300, 32'h77);
    tick();
    seen = cpu_ready;
    reset = 1'b1;
    tick();
    seen = seen | cpu_ready;
    n_checks++;
    if (seen !== 1'b0 || {cpu_rd, cpu_err, s_sel, s_we, s_addr, s_wd, err_count, err_addr} !== '0)
    begin
      n_fail++;
      $display("FAIL abort_outputs: got rdy_seen=%b sel=%b we=%b addr=%h cnt=%0d want all 0",
               seen, s_sel, s_we, s_addr, err_count);
    end
    reset = 1'b0;
    tick();
    s_ready = 4'b0001;
    issue(1'b0, 32'h0000_0010, 32'h0);
    wait_ready(lat);
    n_checks++;
    if (lat !== 2 || cpu_rd !== 32'hA5A50000 || cpu_err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_recover: got lat=%0d rd=%h err=%b want 2 a5a50000 0",
               lat, cpu_rd, cpu_err);
    end
    tick();
    s_ready = 4'b0000;
  endtask

  task automatic test_back_to_back();
    int done = 0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0A40;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (cpu_ready) done++;
    end
    cpu_req = 1'b0;
    tick();
    n_checks++;
    if (done !== 300) begin
      n_fail++;
      $display("FAIL b2b_completions: got %0d want 300", done);
    end
    n_checks++;
    if (err_count !== 8'd255 || err_addr !== 32'h0A40) begin
      n_fail++;
      $display("FAIL b2b_saturate: got cnt=%0d addr=%h want 255 00000a40", err_count, err_addr);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_unmapped();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
